sipo_capture: RTL

Serial-to-parallel capture stage that sits directly downstream of the `dffre_inst` enable/reset flip-flop. It consumes the registered bit stream (`o_Q`) together with the bit-valid qualifier that drives that flop's enable, and assembles the bits into WIDTH-bit words. Completed words are presented on a single-entry valid/ready output register. A word that completes while the output register is still occupied is dropped and latches a sticky overflow flag.

---
 rtl/sipo_capture_pkg.sv | 12 +
 rtl/sipo_capture_shift.sv | 47 ++++
 rtl/sipo_capture.sv | 91 +++++++++
 3 files changed

// File: rtl/sipo_capture_pkg.sv
// Shared types and limits for the sipo_capture serial-to-parallel stage.
package sipo_capture_pkg;

    localparam int unsigned SIPO_WIDTH_MIN = 2;
    localparam int unsigned SIPO_WIDTH_MAX = 32;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_capture_shift.sv
// Shift register and bit counter; flags the enabled edge that completes a word.
module sipo_shift #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       i_Reset,
    input  logic                       enable,
    input  logic                       d,
    output logic [WIDTH-1:0]           word_c,
    output logic                       done_c,
    output logic [$clog2(WIDTH)-1:0]   bit_count
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] shifted;

    // Word as it would look after inserting the current bit.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {sr_q[WIDTH-2:0], d};
        end else begin
            shifted = {d, sr_q[WIDTH-1:1]};
        end
    end

    assign word_c = shifted;
    assign done_c = enable && (bit_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!i_Reset) begin
            sr_q      <= '0;
            bit_count <= '0;
        end else if (enable) begin
            if (done_c) begin
                sr_q      <= '0;
                bit_count <= '0;
            end else begin
                sr_q      <= shifted;
                bit_count <= bit_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sipo_capture.sv
// Serial-to-parallel capture with a single-entry valid/ready output register
// and a sticky overflow flag for words that complete while the output is full.
module sipo_capture
    import sipo_capture_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       i_Reset,
    input  logic                       i_Enable,
    input  logic                       i_D,
    input  logic                       i_Ready,
    output logic [WIDTH-1:0]           o_Data,
    output logic                       o_Valid,
    output logic                       o_Overflow,
    output logic [$clog2(WIDTH)-1:0]   o_BitCount
);

    if (WIDTH < SIPO_WIDTH_MIN || WIDTH > SIPO_WIDTH_MAX) begin : g_width_check
        $error("sipo_capture: WIDTH out of range 2..32");
    end

    sipo_state_t      state_q, state_nx;
    logic [WIDTH-1:0] data_nx;
    logic             valid_nx;
    logic             ovf_nx;
    logic [WIDTH-1:0] word_c;
    logic             done_c;

    sipo_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .i_Reset   (i_Reset),
        .enable    (i_Enable),
        .d         (i_D),
        .word_c    (word_c),
        .done_c    (done_c),
        .bit_count (o_BitCount)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_nx = state_q;
        data_nx  = o_Data;
        valid_nx = o_Valid;
        ovf_nx   = o_Overflow;
        case (state_q)
            ST_EMPTY: begin
                if (done_c) begin
                    state_nx = ST_FULL;
                    data_nx  = word_c;
                    valid_nx = 1'b1;
                end
            end
            ST_FULL: begin
                if (i_Ready) begin
                    if (done_c) begin
                        data_nx = word_c;
                    end else begin
                        state_nx = ST_EMPTY;
                        valid_nx = 1'b0;
                    end
                end else if (done_c) begin
                    ovf_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_EMPTY;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_Reset) begin
            state_q    <= ST_EMPTY;
            o_Data     <= '0;
            o_Valid    <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            state_q    <= state_nx;
            o_Data     <= data_nx;
            o_Valid    <= valid_nx;
            o_Overflow <= ovf_nx;
        end
    end

endmodule
